frame_update_sched: RTL

//  Per-frame scheduler for game-object position updates. On each VGA frame start it grants the update engines one at a time, in fixed order.
//  The engines are blue player, slims, snowflakes and ground. Finally it pulses a commit strobe so shadow coordinates are copied to display registers.

---
 rtl/frame_sched_pkg.sv | 28 ++
 rtl/frame_event_det.sv | 40 ++++
 rtl/frame_update_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared constants for the per-frame object update scheduler.
// Holds the state encoding, client slot names and default sizing used by
// frame_update_sched and frame_event_det.
package frame_sched_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_ADVANCE = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_GRANT   = S_GRANT,
    ST_ADVANCE = S_ADVANCE,
    ST_COMMIT  = S_COMMIT
  } sched_state_e;

  // Client slots in grant order: lower index is granted first.
  localparam int CL_BLUE   = 0;
  localparam int CL_SLIM   = 1;
  localparam int CL_SNOWF  = 2;
  localparam int CL_GROUND = 3;

  localparam int DEF_N_CLIENTS = 4;
  localparam int DEF_TIMEOUT   = 4096;
  localparam int TIMER_W       = 13;

endpackage

// File: rtl/frame_event_det.sv
// frame_event_det: detects the transition of vs into its active level and
// divides those frame events by FRAME_DIV. fev marks every frame start,
// fire marks only the frame starts on which an update sequence should run.
module frame_event_det #(
  parameter int   FRAME_DIV = 1,
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic vs,
  output logic fev,
  output logic fire
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic       vs_q_r;
  logic [7:0] div_r;

  assign fev  = (vs == VS_ACTIVE) && (vs_q_r != VS_ACTIVE);
  assign fire = fev && (div_r == DIV_LAST);

  // Remember last vs level and count frame events toward the next firing one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_q_r <= ~VS_ACTIVE;
      div_r  <= 8'd0;
    end else begin
      vs_q_r <= vs;
      if (fev) begin
        if (div_r == DIV_LAST) begin
          div_r <= 8'd0;
        end else begin
          div_r <= div_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_update_sched.sv
// frame_update_sched: on each (divided) frame start, grants the enabled
// update engines one at a time in index order, then pulses commit so the
// shadow coordinates are copied to the display registers.
// Optional feature macro FRAME_SCHED_TIMEOUT_EN: adds a per-grant timer that
// closes a grant after TIMEOUT cycles without done and flags timeout_err.
module frame_update_sched
  import frame_sched_pkg::*;
#(
  parameter int   N_CLIENTS = DEF_N_CLIENTS,
  parameter int   FRAME_DIV = 1,
  parameter int   TIMEOUT   = DEF_TIMEOUT,
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 vs,
  input  logic                 pause,
  input  logic [N_CLIENTS-1:0] client_en,
  input  logic [N_CLIENTS-1:0] upd_done,
  input  logic                 err_clr,
  output logic [N_CLIENTS-1:0] upd_go,
  output logic                 commit,
  output logic                 busy,
  output logic [N_CLIENTS-1:0] timeout_err,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  sched_state_e         state_r;
  logic [N_CLIENTS-1:0] en_q_r;
  logic [IDX_W-1:0]     idx_r;

  logic                 fev_s;
  logic                 fire_s;
  logic                 done_s;
  logic                 tmo_s;
  logic [N_CLIENTS-1:0] above_s;
  logic [IDX_W:0]       first_s;
  logic [IDX_W:0]       next_s;
  logic [N_CLIENTS-1:0] err_set_s;

  // Lowest set bit of mask as {valid, index}; the downward scan leaves the lowest one.
  function automatic logic [IDX_W:0] pick_lowest(input logic [N_CLIENTS-1:0] mask);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      r = mask[i] ? {1'b1, IDX_W'(i)} : r;
    end
    return r;
  endfunction

  function automatic logic [N_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CLIENTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  frame_event_det #(
    .FRAME_DIV (FRAME_DIV),
    .VS_ACTIVE (VS_ACTIVE)
  ) u_event (
    .clk  (clk),
    .rstn (rstn),
    .vs   (vs),
    .fev  (fev_s),
    .fire (fire_s)
  );

  // Latched clients strictly above the one just served; feeds the advance step.
  always_comb begin
    above_s = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      above_s[i] = en_q_r[i] && (IDX_W'(i) > idx_r);
    end
  end

  assign first_s   = pick_lowest(client_en);
  assign next_s    = pick_lowest(above_s);
  assign done_s    = upd_done[idx_r];
  assign err_set_s = ((state_r == ST_GRANT) && tmo_s && !done_s) ? onehot(idx_r) : '0;

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);
  logic [TIMER_W-1:0] timer_r;

  assign tmo_s = (timer_r == TMO_LAST);

  // Grant timer: held at zero outside GRANT so each grant counts from zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_r <= '0;
    end else if (state_r != ST_GRANT) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TIMER_W'(1);
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Sequencer: walk the latched enable mask one grant at a time, then commit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      en_q_r    <= '0;
      idx_r     <= '0;
      upd_go    <= '0;
      commit    <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      commit <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fire_s && !pause) begin
            en_q_r <= client_en;
            busy   <= 1'b1;
            if (first_s[IDX_W]) begin
              idx_r   <= first_s[IDX_W-1:0];
              upd_go  <= onehot(first_s[IDX_W-1:0]);
              state_r <= ST_GRANT;
            end else begin
              // Empty mask: pass through the idle advance slot, which finds
              // nothing further and moves on to commit.
              state_r <= ST_ADVANCE;
            end
          end
        end
        ST_GRANT: begin
          if (done_s || tmo_s) begin
            upd_go  <= '0;
            state_r <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (next_s[IDX_W]) begin
            idx_r   <= next_s[IDX_W-1:0];
            upd_go  <= onehot(next_s[IDX_W-1:0]);
            state_r <= ST_GRANT;
          end else begin
            commit  <= 1'b1;
            state_r <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 16'd1;
          state_r   <= ST_IDLE;
        end
        default: begin
          upd_go  <= '0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr stays set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      if (fev_s && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      timeout_err <= (err_clr ? '0 : timeout_err) | err_set_s;
    end
  end

endmodule
